// File: rtl/rename_map_table.sv
// rename_map_table: register alias table for the rename stage.
// Maps architectural registers to physical tags. For each accepted
// instruction it translates the sources, pops one tag from free_pool for
// rd, and registers the renamed uop together with the displaced rd tag.
// Optional feature macro: RENAME_CKPT_EN adds ckpt_save/ckpt_restore ports
// and one shadow copy of the table.
module rename_map_table #(
    parameter int ARCH_REGS  = 32,
    parameter int ARCH_WIDTH = 5,
    parameter int PHYS_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ARCH_WIDTH-1:0] in_rs1,
    input  logic [ARCH_WIDTH-1:0] in_rs2,
    input  logic [ARCH_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wr,
    output logic                  fl_pop,
    input  logic [PHYS_WIDTH-1:0] fl_data,
    input  logic                  fl_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PHYS_WIDTH-1:0] out_prs1,
    output logic [PHYS_WIDTH-1:0] out_prs2,
    output logic [PHYS_WIDTH-1:0] out_prd,
    output logic [PHYS_WIDTH-1:0] out_old_prd,
    output logic                  out_alloc
`ifdef RENAME_CKPT_EN
    ,
    input  logic                  ckpt_save,
    input  logic                  ckpt_restore
`endif
);

    logic [PHYS_WIDTH-1:0] rat      [ARCH_REGS];
    logic [PHYS_WIDTH-1:0] rat_next [ARCH_REGS];

    logic                  need_alloc;
    logic                  accept;
    logic                  restore_req;
    logic [PHYS_WIDTH-1:0] prs1_p0;
    logic [PHYS_WIDTH-1:0] prs2_p0;
    logic [PHYS_WIDTH-1:0] prd_p0;
    logic [PHYS_WIDTH-1:0] old_prd_p0;

    logic                  vld_p1;
    logic [PHYS_WIDTH-1:0] prs1_p1;
    logic [PHYS_WIDTH-1:0] prs2_p1;
    logic [PHYS_WIDTH-1:0] prd_p1;
    logic [PHYS_WIDTH-1:0] old_prd_p1;
    logic                  alloc_p1;

`ifdef RENAME_CKPT_EN
    logic [PHYS_WIDTH-1:0] shadow [ARCH_REGS];
    assign restore_req = ckpt_restore;
`else
    assign restore_req = 1'b0;
`endif

    // ---- p0: handshake, source lookup and tag allocation ----
    // x0 is never renamed, so writes to it need no tag.
    assign need_alloc = in_rd_wr && (in_rd != '0);

    // Stall on a full output slot, on an empty pool when a tag is needed,
    // and while a checkpoint restore is in progress.
    assign in_ready = (!vld_p1 || out_ready) && !(need_alloc && fl_empty) && !restore_req;
    assign accept   = in_valid && in_ready;
    assign fl_pop   = accept && need_alloc;

    // Sources read the table before this instruction's own update; RAT[0]
    // stays 0 forever, so x0 reads tag 0.
    assign prs1_p0    = rat[in_rs1];
    assign prs2_p0    = rat[in_rs2];
    assign prd_p0     = need_alloc ? fl_data : '0;
    assign old_prd_p0 = need_alloc ? rat[in_rd] : '0;

    // Next table contents: restore takes the shadow, else apply the rd update.
    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            rat_next[i] = rat[i];
        end
`ifdef RENAME_CKPT_EN
        if (restore_req) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_next[i] = shadow[i];
            end
        end else
`endif
        if (fl_pop) begin
            rat_next[in_rd] = fl_data;
        end
    end

    // Alias table storage; reset to the identity mapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= PHYS_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= rat_next[i];
            end
        end
    end

`ifdef RENAME_CKPT_EN
    // Shadow table captures the post-update mapping; restore blocks a save.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                shadow[i] <= PHYS_WIDTH'(i);
            end
        end else if (ckpt_save && !restore_req) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                shadow[i] <= rat_next[i];
            end
        end
    end
`endif

    // ---- p1: renamed uop output register ----
    // Loads on accept, drains when consumed, holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            prs1_p1    <= '0;
            prs2_p1    <= '0;
            prd_p1     <= '0;
            old_prd_p1 <= '0;
            alloc_p1   <= 1'b0;
        end else if (restore_req) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            prs1_p1    <= prs1_p0;
            prs2_p1    <= prs2_p0;
            prd_p1     <= prd_p0;
            old_prd_p1 <= old_prd_p0;
            alloc_p1   <= need_alloc;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_prs1    = prs1_p1;
    assign out_prs2    = prs2_p1;
    assign out_prd     = prd_p1;
    assign out_old_prd = old_prd_p1;
    assign out_alloc   = alloc_p1;

endmodule
